// File: rtl/sgd_pkg.sv
// rtl/sgd_pkg.sv - shared types and constants for the SGD step sequencer
//
// Contents:
//   sgd_state_e  - sequencer states IDLE..FIN
//   FRAC_BITS    - Q8.8 fraction width of the datapath words
//   LR_SHIFT     - learning-rate shift applied by the weight-update path
//   clog2_min1   - ceil(log2(value)), never less than 1 (for index widths)

package sgd_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_PRED  = 3'd2,
        S_ERR   = 3'd3,
        S_UPD   = 3'd4,
        S_WB    = 3'd5,
        S_FIN   = 3'd6
    } sgd_state_e;

    localparam int FRAC_BITS = 8;
    localparam int LR_SHIFT  = 7;

    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/sgd_wait_timer.sv
// rtl/sgd_wait_timer.sv - loadable down-counter with a zero flag
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load        load load_val this cycle (takes priority over counting)
//   load_val    value to load
//   zero        high while the count is zero; the counter parks at zero

module sgd_wait_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sgd_step_sequencer.sv
// rtl/sgd_step_sequencer.sv - epoch/datapoint sequencer for the SGD linear-regression datapath
//
// Optional feature macro: SGD_EARLY_STOP_EN (early stop when every |error| of an
// epoch is within ERR_TOL). Without it err_in is ignored and stopped_early is 0.
//
// Ports:
//   CLK, RSTN      clock, asynchronous active-low reset
//   start          begin a run (sampled in IDLE only, ignored together with abort)
//   abort          return to IDLE from any state, counters hold
//   n_epochs       epochs to run, captured on accepted start
//   err_in         signed Q8.8 error from the datapath, sampled in ERR
//   busy           high in FETCH..WB
//   done           one-cycle pulse in FIN on normal completion
//   dp_idx         current datapoint / sample RAM row
//   epoch_idx      current epoch, 0-based
//   fetch          strobe: load row dp_idx into the multipliers
//   err_latch      strobe: register error[dp_idx]
//   w_wr_en        strobe: commit the weight updates
//   stopped_early  sticky: last run ended by early stop

module sgd_step_sequencer
    import sgd_pkg::*;
#(
    parameter int              DP       = 4,
    parameter int              MUL_LAT  = 3,
    parameter int              EPOCH_W  = 16,
    parameter int              BITS     = 16,
    parameter logic [BITS-1:0] ERR_TOL  = 16'h0010,
    localparam int             DP_W     = clog2_min1(DP)
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic                   start,
    input  logic                   abort,
    input  logic [EPOCH_W-1:0]     n_epochs,
    input  logic signed [BITS-1:0] err_in,
    output logic                   busy,
    output logic                   done,
    output logic [DP_W-1:0]        dp_idx,
    output logic [EPOCH_W-1:0]     epoch_idx,
    output logic                   fetch,
    output logic                   err_latch,
    output logic                   w_wr_en,
    output logic                   stopped_early
);

    localparam int              TMR_W   = clog2_min1(MUL_LAT + 2);
    localparam logic [DP_W-1:0] DP_LAST = DP_W'(DP - 1);

    sgd_state_e         state, state_d;
    logic [EPOCH_W-1:0] n_epochs_q;
    logic [EPOCH_W-1:0] epoch_inc;
    logic               accept;
    logic               wb_commit;
    logic               last_dp;
    logic               early_hit;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_zero;

    assign accept    = (state == S_IDLE) && start && !abort;
    assign wb_commit = (state == S_WB) && !abort;
    assign last_dp   = (dp_idx == DP_LAST);
    assign epoch_inc = epoch_idx + EPOCH_W'(1);

    sgd_wait_timer #(
        .W(TMR_W)
    ) u_wait_timer (
        .clk     (CLK),
        .rst_n   (RSTN),
        .load    (tmr_load),
        .load_val(tmr_val),
        .zero    (tmr_zero)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // The timer is loaded on the transition into PRED/UPD so the wait state
    // sees load_val, load_val-1, ..., 0: PRED lasts MUL_LAT+1 cycles and UPD
    // lasts MUL_LAT cycles, giving a 2*MUL_LAT+4 cycle datapoint step.
    always_comb begin
        state_d  = state;
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (state != S_IDLE && abort) begin
            state_d = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state_d = (n_epochs == '0) ? S_FIN : S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_d  = S_PRED;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(MUL_LAT);
                end
                S_PRED: begin
                    if (tmr_zero) begin
                        state_d = S_ERR;
                    end
                end
                S_ERR: begin
                    state_d  = S_UPD;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(MUL_LAT - 1);
                end
                S_UPD: begin
                    if (tmr_zero) begin
                        state_d = S_WB;
                    end
                end
                S_WB: begin
                    if (last_dp && (epoch_inc == n_epochs_q || early_hit)) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_FIN:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            n_epochs_q <= '0;
            dp_idx     <= '0;
            epoch_idx  <= '0;
        end else if (accept) begin
            n_epochs_q <= n_epochs;
            dp_idx     <= '0;
            epoch_idx  <= '0;
        end else if (wb_commit) begin
            if (last_dp) begin
                dp_idx    <= '0;
                epoch_idx <= epoch_inc;
            end else begin
                dp_idx <= dp_idx + DP_W'(1);
            end
        end
    end

    assign busy      = (state == S_FETCH) || (state == S_PRED) || (state == S_ERR) ||
                       (state == S_UPD)   || (state == S_WB);
    assign fetch     = (state == S_FETCH);
    assign err_latch = (state == S_ERR);
    assign w_wr_en   = (state == S_WB)  && !abort;
    assign done      = (state == S_FIN) && !abort;

`ifdef SGD_EARLY_STOP_EN
    logic            all_small;
    logic            stopped_q;
    logic [BITS-1:0] err_mag;

    // Magnitude of err_in; the most-negative code saturates to the largest
    // positive value so it always counts as a large error.
    always_comb begin
        err_mag = err_in;
        if (err_in[BITS-1]) begin
            if (err_in == {1'b1, {(BITS-1){1'b0}}}) begin
                err_mag = {1'b0, {(BITS-1){1'b1}}};
            end else begin
                err_mag = $unsigned(-err_in);
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            all_small <= 1'b0;
        end else if (accept || (wb_commit && last_dp)) begin
            all_small <= 1'b1;
        end else if (state == S_ERR && !abort && err_mag > ERR_TOL) begin
            all_small <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            stopped_q <= 1'b0;
        end else if (accept) begin
            stopped_q <= 1'b0;
        end else if (wb_commit && last_dp && all_small) begin
            stopped_q <= 1'b1;
        end
    end

    assign early_hit     = all_small;
    assign stopped_early = stopped_q;
`else
    logic unused_err;
    assign unused_err    = ^{err_in, ERR_TOL};
    assign early_hit     = 1'b0;
    assign stopped_early = 1'b0;
`endif

    logic unused_fmt;
    assign unused_fmt = ^{FRAC_BITS, LR_SHIFT};

endmodule

// File: tb/tb_sgd_step_sequencer.sv
// tb/tb_sgd_step_sequencer.sv - scoreboard bench for sgd_step_sequencer

module tb_sgd_step_sequencer;

    localparam int DP  = 4;
    localparam int L   = 3;
    localparam int P   = 2 * L + 4;
    localparam int TOL = 16;
`ifdef SGD_EARLY_STOP_EN
    localparam bit ES = 1'b1;
`else
    localparam bit ES = 1'b0;
`endif

    typedef struct {
        int kind;   // 0 fetch, 1 err_latch, 2 w_wr_en, 3 done
        int cyc;
        int dp;
        int ep;
    } ev_t;

    logic        CLK;
    logic        RSTN;
    logic        start;
    logic        abort;
    logic [15:0] n_epochs;
    logic [15:0] err_in;
    logic        busy;
    logic        done;
    logic [1:0]  dp_idx;
    logic [15:0] epoch_idx;
    logic        fetch;
    logic        err_latch;
    logic        w_wr_en;
    logic        stopped_early;

    int  cyc     = 0;
    int  errors  = 0;
    int  checks  = 0;
    int  wr_cnt  = 0;
    int  busy_lo = 0;
    int  busy_hi = 0;
    ev_t q[$];

    sgd_step_sequencer dut (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .start        (start),
        .abort        (abort),
        .n_epochs     (n_epochs),
        .err_in       (err_in),
        .busy         (busy),
        .done         (done),
        .dp_idx       (dp_idx),
        .epoch_idx    (epoch_idx),
        .fetch        (fetch),
        .err_latch    (err_latch),
        .w_wr_en      (w_wr_en),
        .stopped_early(stopped_early)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
        end
    endtask

    // Monitor: every strobe must match the head of the expected-event queue.
    always @(negedge CLK) begin
        int  nstr;
        int  kind;
        bit  exp_busy;
        ev_t e;
        nstr = int'(fetch) + int'(err_latch) + int'(w_wr_en) + int'(done);
        if (nstr != 0) begin
            kind = fetch ? 0 : err_latch ? 1 : w_wr_en ? 2 : 3;
            if (w_wr_en) wr_cnt++;
            checks++;
            if (nstr > 1 || q.size() == 0) begin
                errors++;
                $display("FAIL strobe at cycle %0d: fetch=%b err_latch=%b w_wr_en=%b done=%b, expected a single queued strobe (queued=%0d)",
                         cyc, fetch, err_latch, w_wr_en, done, q.size());
            end else begin
                e = q.pop_front();
                if (e.kind != kind || e.cyc != cyc || e.dp != int'(dp_idx) || e.ep != int'(epoch_idx)) begin
                    errors++;
                    $display("FAIL event: got kind=%0d cyc=%0d dp=%0d ep=%0d, expected kind=%0d cyc=%0d dp=%0d ep=%0d",
                             kind, cyc, dp_idx, epoch_idx, e.kind, e.cyc, e.dp, e.ep);
                end
            end
        end
        exp_busy = (cyc >= busy_lo) && (cyc < busy_hi);
        checks++;
        if (busy !== exp_busy) begin
            errors++;
            $display("FAIL busy at cycle %0d: got %b, expected %b", cyc, busy, exp_busy);
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge CLK);
            #1;
        end
    endtask

    function automatic int mag(input logic [15:0] v);
        int s;
        s = int'($signed(v));
        return (s < 0) ? -s : s;
    endfunction

    // Drop queued events that an abort at cycle ab suppresses.
    task automatic prune(input int ab);
        ev_t keep[$];
        foreach (q[i]) begin
            if (q[i].cyc < ab || (q[i].cyc == ab && q[i].kind < 2)) keep.push_back(q[i]);
        end
        q = keep;
    endtask

    // mode: 0 random errors, 1 epoch0 0x0100 then 0xFFF8, 2 epoch0 0x8000 then 0x0100, 3 all 0x0100
    // brk : 0 none, 1 abort in 2nd PRED cycle of step brk_step, 2 reset in UPD of step brk_step
    task automatic do_run(input int n, input int mode, input int brk, input int brk_step);
        int          c0, steps, fin_ep, done_c, f, ab, wr0;
        bit          stop, small_all, ep_small;
        logic [15:0] v;
        logic [15:0] errs[$];
        c0       = cyc;
        start    = 1'b1;
        n_epochs = 16'(n);
        steps    = 0;
        stop     = 1'b0;
        fin_ep   = n;
        for (int e = 0; e < n && !stop; e++) begin
            small_all = 1'b1;
            ep_small  = ($urandom_range(0, 2) == 0);
            for (int d = 0; d < DP; d++) begin
                case (mode)
                    0:       v = ep_small ? 16'($urandom_range(0, 32) - 16) : 16'($urandom);
                    1:       v = (e == 0) ? 16'h0100 : 16'hFFF8;
                    2:       v = (e == 0) ? 16'h8000 : 16'h0100;
                    default: v = 16'h0100;
                endcase
                errs.push_back(v);
                if (mag(v) > TOL) small_all = 1'b0;
                q.push_back('{0, c0 + 1 + P * steps, d, e});
                q.push_back('{1, c0 + 1 + P * steps + L + 2, d, e});
                q.push_back('{2, c0 + 1 + P * steps + 2 * L + 3, d, e});
                steps++;
            end
            if (ES && small_all) begin
                stop   = 1'b1;
                fin_ep = e + 1;
            end
        end
        done_c = c0 + 1 + P * steps;
        q.push_back('{3, done_c, 0, fin_ep});
        busy_lo = c0 + 1;
        busy_hi = done_c;
        wr0     = wr_cnt;
        wait_until(c0 + 1);
        start = 1'b0;
        for (int k = 0; k < steps; k++) begin
            f = c0 + 1 + P * k;
            if (brk == 1 && k == brk_step) begin
                ab = f + 2;
                wait_until(ab);
                abort = 1'b1;
                prune(ab);
                busy_hi = ab + 1;
                wait_until(ab + 1);
                abort = 1'b0;
                wait_until(ab + 4);
                chk("abort_queue_empty", q.size(), 0);
                chk("abort_dp_hold", dp_idx, brk_step % DP);
                chk("abort_epoch_hold", epoch_idx, brk_step / DP);
                chk("abort_wr_count", wr_cnt - wr0, brk_step);
                return;
            end
            if (brk == 2 && k == brk_step) begin
                ab = f + L + 4;
                wait_until(ab);
                RSTN = 1'b0;
                q.delete();
                busy_hi = ab;
                #1;
                chk("reset_outputs_zero",
                    {busy, done, fetch, err_latch, w_wr_en, stopped_early, dp_idx, epoch_idx}, 0);
                wait_until(ab + 2);
                RSTN = 1'b1;
                wait_until(ab + 3);
                return;
            end
            wait_until(f);
            err_in = errs[k];
            if ($urandom_range(0, 3) == 0) begin
                start    = 1'b1;
                n_epochs = 16'($urandom);
                wait_until(f + 1);
                start = 1'b0;
            end
        end
        wait_until(done_c + 2);
        chk("run_queue_drained", q.size(), 0);
        chk("run_wr_count", wr_cnt - wr0, steps);
        chk("run_stopped_early", stopped_early, stop);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        RSTN     = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        n_epochs = '0;
        err_in   = '0;
        wait_until(3);
        chk("reset_state",
            {busy, done, fetch, err_latch, w_wr_en, stopped_early, dp_idx, epoch_idx}, 0);
        RSTN = 1'b1;
        wait_until(5);

        do_run(2, 3, 0, 0);                         // basic: 8 steps, done 80 cycles after busy
        chk("basic_epoch_final", epoch_idx, 2);
        do_run(0, 0, 0, 0);                         // zero epochs
        do_run(3, 3, 1, 2);                         // abort in dp 2, epoch 0
        do_run(1, 3, 0, 0);                         // normal run after abort
        do_run(2, 3, 2, 5);                         // reset during UPD
        do_run(1, 0, 0, 0);                         // fresh run after reset

        // abort and start together in IDLE: nothing starts
        start    = 1'b1;
        abort    = 1'b1;
        n_epochs = 16'd3;
        wait_until(cyc + 1);
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_idle_busy", busy, 0);
        wait_until(cyc + 3);
        chk("abort_start_idle_queue", q.size(), 0);

        do_run(5, 1, 0, 0);                         // early stop after 2 epochs when enabled
        do_run(2, 2, 0, 0);                         // 0x8000 is never small

        for (int i = 0; i < 8; i++) begin
            if (i % 3 == 2) do_run($urandom_range(1, 3), 0, 1, $urandom_range(0, 7));
            else            do_run($urandom_range(1, 3), 0, 0, 0);
            wait_until(cyc + $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
